// File: rtl/gen_pipe_chain_pkg.sv
// Shared types for the elastic pipeline chain.
// Holds the per-stage action encoding and the priority function that selects it.
// Imported by the stage and by the top level.
package gen_pipe_chain_pkg;

    // Register action for one stage, resolved in priority order
    typedef enum logic [1:0] {
        ACT_KEEP  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_EMPTY = 2'd2,
        ACT_CLEAR = 2'd3
    } stage_act_e;

    // Flush beats hold, hold beats any movement, and a load beats a vacate
    // (a stage that passes its word on and takes a new one stays full).
    function automatic stage_act_e stage_act(
        input logic clr,
        input logic hold,
        input logic load,
        input logic vacate
    );
        stage_act_e act;
        act = ACT_KEEP;
        if (clr) begin
            act = ACT_CLEAR;
        end else if (hold) begin
            act = ACT_KEEP;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (vacate) begin
            act = ACT_EMPTY;
        end
        stage_act = act;
    endfunction

endpackage

// File: rtl/gen_pipe_stage.sv
// One elastic stage: valid bit plus data register, bubble-filled with def_val.
// Latency: one cycle from load to the stage output.
// Backpressure: ready when empty or when the next stage can take this stage's word.
module gen_pipe_stage
    import gen_pipe_chain_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          hold_i,
    input  logic [DW-1:0] def_val_i,
    input  logic          pred_vld_i,
    input  logic [DW-1:0] pred_dat_i,
    input  logic          rdy_nxt_i,
    output logic          rdy_o,
    output logic          vld_o,
    output logic [DW-1:0] dat_o
);

    logic          vld_q;
    logic          vld_d;
    logic [DW-1:0] dat_q;
    logic [DW-1:0] dat_d;
    logic          load;
    logic          vacate;
    stage_act_e    act;

    // Readiness ripples backwards: an empty stage always accepts, a full one
    // only when its own word can move on in the same cycle.
    assign rdy_o  = !vld_q | rdy_nxt_i;
    assign load   = pred_vld_i & rdy_o;
    assign vacate = vld_q & rdy_nxt_i;

    // Pick this cycle's action with flush/hold taking precedence over movement
    always_comb begin
        act = stage_act(flush_i, hold_i, load, vacate);
    end

    // Next-state for the valid bit and data register
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        unique case (act)
            ACT_LOAD: begin
                vld_d = 1'b1;
                dat_d = pred_dat_i;
            end
            ACT_EMPTY, ACT_CLEAR: begin
                vld_d = 1'b0;
                dat_d = def_val_i;
            end
            default: begin
                vld_d = vld_q;
                dat_d = dat_q;
            end
        endcase
    end

    // State registers; reset empties the stage and fills it with def_val
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= def_val_i;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/gen_pipe_chain.sv
// Elastic register chain of DEPTH stages with bubble collapsing, flush, hold and occupancy.
// Latency: DEPTH cycles through an empty chain; one word per cycle sustained.
// Backpressure: in_ready ripples back combinationally from out_ready through full stages.
module gen_pipe_chain
    import gen_pipe_chain_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic [DW-1:0]    def_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] occupancy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] vld;
    logic [DW-1:0]    dat [DEPTH];

    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    assign rdy[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          pred_vld;
        logic [DW-1:0] pred_dat;

        if (k == 0) begin : g_head
            assign pred_vld = in_valid;
            assign pred_dat = in_data;
        end else begin : g_body
            assign pred_vld = vld[k-1];
            assign pred_dat = dat[k-1];
        end

        gen_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush_i    (flush),
            .hold_i     (hold),
            .def_val_i  (def_val),
            .pred_vld_i (pred_vld),
            .pred_dat_i (pred_dat),
            .rdy_nxt_i  (rdy[k+1]),
            .rdy_o      (rdy[k]),
            .vld_o      (vld[k]),
            .dat_o      (dat[k])
        );
    end

    // Port gating: flush and hold suppress handshakes on both ends
    assign in_ready  = rdy[0] & !hold & !flush & !rst;
    assign out_valid = vld[DEPTH-1] & !hold & !flush;
    assign out_data  = dat[DEPTH-1];

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Occupancy tracks accepted minus delivered words; flush clears it
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + CNT_ONE;
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - CNT_ONE;
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
